// File: rtl/user_ram_bridge.sv
// rtl/user_ram_bridge.sv - CPU valid/ready bus to single-port user RAM controller
//
// Decodes a 4*2^ADDR_BIT byte window at BASE_ADDR and drives one user RAM.
// Reads wait RD_LAT cycles after the first read-enable cycle before sampling
// ram_do_i. Full-word writes go straight to the RAM; byte-masked writes are
// done as read-modify-write. All outputs are registered.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   mem_valid_i           request valid, held until mem_ready_o
//   mem_addr_i[31:0]      byte address
//   mem_wdata_i[31:0]     write data
//   mem_wstrb_i[3:0]      byte strobes, 0 = read
//   mem_ready_o           one-cycle completion pulse
//   mem_rdata_o[31:0]     read data, holds last read value
//   ram_wr_en_o           RAM write enable
//   ram_rd_en_o           RAM read enable
//   ram_addr_o            RAM word address
//   ram_di_o[31:0]        RAM write data
//   ram_do_i[31:0]        RAM read data

module user_ram_bridge #(
    parameter int          ADDR_BIT  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
    parameter int          RD_LAT    = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                mem_valid_i,
    input  logic [31:0]         mem_addr_i,
    input  logic [31:0]         mem_wdata_i,
    input  logic [3:0]          mem_wstrb_i,
    output logic                mem_ready_o,
    output logic [31:0]         mem_rdata_o,
    output logic                ram_wr_en_o,
    output logic                ram_rd_en_o,
    output logic [ADDR_BIT-1:0] ram_addr_o,
    output logic [31:0]         ram_di_o,
    input  logic [31:0]         ram_do_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RMW_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(RD_LAT);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_BIT-1:0] addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [31:0]         di_q, di_d;
    logic                rd_en_q, rd_en_d;
    logic                wr_en_q, wr_en_d;
    logic                ready_q, ready_d;
    logic [31:0]         rdata_q, rdata_d;

    logic                hit;
    logic [31:0]         merged;
    logic                addr_lsb_unused;

    // Byte address bits [1:0] play no part in a word-wide RAM.
    assign addr_lsb_unused = ^mem_addr_i[1:0];

    assign hit = mem_valid_i &&
                 (mem_addr_i[31:ADDR_BIT+2] == BASE_ADDR[31:ADDR_BIT+2]);

    always_comb begin
        merged = ram_do_i;
        for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) begin
                merged[8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        di_d    = di_q;
        rd_en_d = rd_en_q;
        wr_en_d = wr_en_q;
        ready_d = 1'b0;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    addr_d  = mem_addr_i[ADDR_BIT+1:2];
                    wdata_d = mem_wdata_i;
                    wstrb_d = mem_wstrb_i;
                    if (mem_wstrb_i == 4'h0) begin
                        state_d = S_RD_WAIT;
                        rd_en_d = 1'b1;
                        cnt_d   = LAT_LOAD;
                    end else if (mem_wstrb_i == 4'hF) begin
                        state_d = S_WRITE;
                        wr_en_d = 1'b1;
                        di_d    = mem_wdata_i;
                        // A full write lingers one extra cycle in WRITE so it
                        // completes two cycles after its write pulse.
                        cnt_d   = 4'd1;
                    end else begin
                        state_d = S_RMW_WAIT;
                        rd_en_d = 1'b1;
                        cnt_d   = LAT_LOAD;
                    end
                end
            end
            S_RD_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = ram_do_i;
                    rd_en_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RMW_WAIT: begin
                if (cnt_q == 4'd0) begin
                    di_d    = merged;
                    rd_en_d = 1'b0;
                    wr_en_d = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WRITE: begin
                wr_en_d = 1'b0;
                if (cnt_q == 4'd0) begin
                    ready_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                // Leave the RAM pins quiet while idle.
                addr_d  = '0;
                di_d    = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            di_q    <= '0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            di_q    <= di_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_ready_o = ready_q;
    assign mem_rdata_o = rdata_q;
    assign ram_wr_en_o = wr_en_q;
    assign ram_rd_en_o = rd_en_q;
    assign ram_addr_o  = addr_q;
    assign ram_di_o    = di_q;

endmodule

// File: tb/tb_user_ram_bridge.sv
// tb/tb_user_ram_bridge.sv - scoreboard bench for user_ram_bridge
module tb_user_ram_bridge;

    localparam int          ADDR_BIT = 6;
    localparam int          RD_LAT   = 3;
    localparam logic [31:0] BASE     = 32'h0001_0000;
    localparam int          WORDS    = 1 << ADDR_BIT;

    logic                clk = 1'b0;
    logic                rst_i;
    logic                mem_valid_i;
    logic [31:0]         mem_addr_i;
    logic [31:0]         mem_wdata_i;
    logic [3:0]          mem_wstrb_i;
    logic                mem_ready_o;
    logic [31:0]         mem_rdata_o;
    logic                ram_wr_en_o;
    logic                ram_rd_en_o;
    logic [ADDR_BIT-1:0] ram_addr_o;
    logic [31:0]         ram_di_o;
    logic [31:0]         ram_do_i;

    always #5 clk = ~clk;

    user_ram_bridge #(
        .ADDR_BIT  (ADDR_BIT),
        .BASE_ADDR (BASE),
        .RD_LAT    (RD_LAT)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .mem_valid_i (mem_valid_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_wstrb_i (mem_wstrb_i),
        .mem_ready_o (mem_ready_o),
        .mem_rdata_o (mem_rdata_o),
        .ram_wr_en_o (ram_wr_en_o),
        .ram_rd_en_o (ram_rd_en_o),
        .ram_addr_o  (ram_addr_o),
        .ram_di_o    (ram_di_o),
        .ram_do_i    (ram_do_i)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return 32'h3C5A_0000 ^ (32'(i) * 32'h0101_0103);
    endfunction

    // User RAM: data is only valid in the RD_LAT-th cycle after the first
    // read-enable cycle; any other time it returns a junk pattern.
    logic [31:0] ram_mem [WORDS];
    int          rd_run  = 0;
    bit          preload = 1'b1;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < WORDS; i++) ram_mem[i] <= init_word(i);
        end else if (ram_wr_en_o) begin
            ram_mem[ram_addr_o] <= ram_di_o;
        end
        rd_run <= ram_rd_en_o ? rd_run + 1 : 0;
    end

    assign ram_do_i = (ram_rd_en_o && rd_run == RD_LAT) ? ram_mem[ram_addr_o] : 32'h5A5A_A5A5;

    // Reference model and per-cycle expectations.
    logic [31:0]         model_mem [WORDS];
    logic [31:0]         last_rd;
    bit                  exp_rd   [int];
    logic [31:0]         exp_wr   [int];
    logic [ADDR_BIT-1:0] exp_addr [int];
    bit                  exp_rdy  [int];
    logic [31:0]         rsp_q    [$];
    logic [31:0]         mon_e;

    // Monitor
    always @(negedge clk) begin
        if (rst_i) begin
            chk("rst_rd_en", 32'(ram_rd_en_o), 32'd0);
            chk("rst_wr_en", 32'(ram_wr_en_o), 32'd0);
            chk("rst_ready", 32'(mem_ready_o), 32'd0);
        end else begin
            chk("rd_en",  32'(ram_rd_en_o), 32'(exp_rd.exists(cyc)));
            chk("wr_en",  32'(ram_wr_en_o), 32'(exp_wr.exists(cyc)));
            chk("ready",  32'(mem_ready_o), 32'(exp_rdy.exists(cyc)));
            chk("en_exclusive", 32'(ram_rd_en_o & ram_wr_en_o), 32'd0);
            if (exp_addr.exists(cyc)) chk("ram_addr", 32'(ram_addr_o), 32'(exp_addr[cyc]));
            if (ram_wr_en_o && exp_wr.exists(cyc)) chk("ram_di", ram_di_o, exp_wr[cyc]);
            if (mem_ready_o) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    mon_e = rsp_q.pop_front();
                    chk("rdata", mem_rdata_o, mon_e);
                end
            end
        end
    end

    task automatic idle(input int n);
        mem_valid_i = 1'b0;
        mem_wstrb_i = 4'h0;
        repeat (n) @(negedge clk);
    endtask

    task automatic miss(input logic [31:0] addr, input logic [3:0] strb, input int n);
        mem_valid_i = 1'b1;
        mem_addr_i  = addr;
        mem_wstrb_i = strb;
        mem_wdata_i = $urandom;
        repeat (n) @(negedge clk);
        mem_valid_i = 1'b0;
    endtask

    // Called at a negedge. b2b: the previous request's ready was seen at this
    // negedge, so the bridge is in DONE now and accepts one cycle later.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input bit b2b, input bit alter);
        int          c0;
        int          last;
        int          idx;
        logic [31:0] merged;
        bit          done;
        c0  = b2b ? cyc + 1 : cyc;
        idx = int'(addr[ADDR_BIT+1:2]);
        if (wstrb == 4'h0) begin
            for (int c = c0 + 1; c <= c0 + 1 + RD_LAT; c++) exp_rd[c] = 1'b1;
            last    = c0 + 2 + RD_LAT;
            last_rd = model_mem[idx];
        end else begin
            for (int b = 0; b < 4; b++)
                merged[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : model_mem[idx][8*b +: 8];
            if (wstrb == 4'hF) begin
                exp_wr[c0 + 1] = merged;
                last = c0 + 3;
            end else begin
                for (int c = c0 + 1; c <= c0 + 1 + RD_LAT; c++) exp_rd[c] = 1'b1;
                exp_wr[c0 + 2 + RD_LAT] = merged;
                last = c0 + 3 + RD_LAT;
            end
            model_mem[idx] = merged;
        end
        rsp_q.push_back(last_rd);
        for (int c = c0 + 1; c <= last; c++) exp_addr[c] = addr[ADDR_BIT+1:2];
        exp_rdy[last] = 1'b1;

        mem_valid_i = 1'b1;
        mem_addr_i  = addr;
        mem_wdata_i = wdata;
        mem_wstrb_i = wstrb;
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (alter && cyc == c0 + 2) begin
                mem_addr_i  = $urandom;
                mem_wdata_i = $urandom;
            end
            if (mem_ready_o) done = 1'b1;
        end
        if (!done) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  s;
        int          c0;
        int          kind;
        bit          b2b;
        bit          prev_txn;

        rst_i       = 1'b1;
        mem_valid_i = 1'b0;
        mem_addr_i  = '0;
        mem_wdata_i = '0;
        mem_wstrb_i = '0;
        for (int i = 0; i < WORDS; i++) model_mem[i] = init_word(i);
        last_rd = '0;

        repeat (2) @(negedge clk);
        chk("reset_ready", 32'(mem_ready_o), 32'd0);
        chk("reset_rdata", mem_rdata_o, 32'd0);
        chk("reset_wr_en", 32'(ram_wr_en_o), 32'd0);
        chk("reset_rd_en", 32'(ram_rd_en_o), 32'd0);
        chk("reset_addr",  32'(ram_addr_o), 32'd0);
        chk("reset_di",    ram_di_o, 32'd0);
        preload = 1'b0;
        rst_i   = 1'b0;
        idle(2);

        // Full write then back-to-back read-back.
        run_txn(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
        run_txn(BASE + 32'h10, 32'h0, 4'h0, 1'b1, 1'b0);
        chk("readback_deadbeef", mem_rdata_o, 32'hDEAD_BEEF);
        idle(2);

        // Partial write merge.
        run_txn(BASE + 32'h20, 32'h1122_3344, 4'hF, 1'b0, 1'b0);
        idle(1);
        run_txn(BASE + 32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0, 1'b0);
        idle(1);
        run_txn(BASE + 32'h20, 32'h0, 4'h0, 1'b0, 1'b0);
        chk("partial_merge", mem_rdata_o, 32'h11BB_33DD);
        idle(1);

        // Outside the window.
        miss(BASE + 32'(4 * WORDS), 4'h0, 20);
        miss(BASE - 32'd4, 4'hF, 5);
        idle(1);

        // Back-to-back reads of words 0 and 1.
        run_txn(BASE, 32'h0, 4'h0, 1'b0, 1'b0);
        run_txn(BASE + 32'h4, 32'h0, 4'h0, 1'b1, 1'b0);
        idle(2);

        // Inputs changed mid-transaction.
        run_txn(BASE + 32'h30, 32'h0, 4'h0, 1'b0, 1'b1);
        idle(1);
        run_txn(BASE + 32'h30, 32'hCAFE_F00D, 4'b1010, 1'b0, 1'b1);
        idle(1);
        run_txn(BASE + 32'h30, 32'h0, 4'h0, 1'b0, 1'b1);
        idle(2);

        // Reset during the read phase of a read-modify-write.
        a  = BASE + 32'h20;
        c0 = cyc;
        for (int c = c0 + 1; c <= c0 + 1 + RD_LAT; c++) begin
            exp_rd[c]   = 1'b1;
            exp_addr[c] = a[ADDR_BIT+1:2];
        end
        mem_valid_i = 1'b1;
        mem_addr_i  = a;
        mem_wdata_i = 32'hFFFF_FFFF;
        mem_wstrb_i = 4'b0011;
        repeat (2) @(negedge clk);
        chk("rmw_rd_active", 32'(ram_rd_en_o), 32'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("async_rst_rd_en", 32'(ram_rd_en_o), 32'd0);
        chk("async_rst_wr_en", 32'(ram_wr_en_o), 32'd0);
        chk("async_rst_ready", 32'(mem_ready_o), 32'd0);
        chk("async_rst_addr",  32'(ram_addr_o), 32'd0);
        mem_valid_i = 1'b0;
        exp_rd.delete();
        exp_addr.delete();
        last_rd = '0;
        repeat (4) @(negedge clk);
        rst_i = 1'b0;
        idle(2);
        run_txn(a, 32'h0, 4'h0, 1'b0, 1'b0);
        chk("rmw_aborted_word", mem_rdata_o, 32'h11BB_33DD);

        // Randomized traffic.
        prev_txn = 1'b1;
        for (int t = 0; t < 150; t++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                idle(1);
                miss(BASE ^ (32'h1 << $urandom_range(ADDR_BIT + 2, 31)),
                     4'($urandom_range(0, 15)), $urandom_range(2, 6));
                idle(1);
                prev_txn = 1'b0;
            end else begin
                a = BASE | ($urandom & 32'(4 * WORDS - 1));
                if (kind <= 3)      s = 4'h0;
                else if (kind <= 6) s = 4'hF;
                else                s = 4'($urandom_range(1, 14));
                b2b = prev_txn && ($urandom_range(0, 1) == 1);
                if (!b2b) idle($urandom_range(1, 3));
                run_txn(a, $urandom, s, b2b, $urandom_range(0, 3) == 0);
                prev_txn = 1'b1;
            end
        end

        idle(4);
        chk("scoreboard_drained", 32'(rsp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
